// File: rtl/hex_scan_decoder.sv
// Samples a time-multiplexed active-low seven-segment bus, waits for each digit
// pattern to be stable, and decodes it back into per-digit hex nibbles.
module hex_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      Sel_valid,
  input  logic [2:0]                Sel_in,
  input  logic [6:0]                Seg_in,
  output logic [4*NUM_DIGITS-1:0]   Hex_out,
  output logic [NUM_DIGITS-1:0]     Digit_valid,
  output logic [NUM_DIGITS-1:0]     Digit_err,
  output logic                      Update,
  output logic [2:0]                Update_idx,
  output logic                      Frame_done
);

  localparam int unsigned   CW  = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

  logic [2:0]              r_last_sel;
  logic [6:0]              r_last_seg;
  logic [CW-1:0]           r_cnt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_update;
  logic [2:0]              r_update_idx;
  logic                    r_frame;

  logic [3:0]              w_nib;
  logic                    w_legal;
  logic                    w_blank;
  logic                    w_in_range;
  logic                    w_match;
  logic [CW-1:0]           w_cnt_next;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  logic                    w_frame;

  always_comb begin
    w_nib   = '0;
    w_legal = 1'b1;
    w_blank = 1'b0;
    case (Seg_in)
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0010000: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b0000011: w_nib = 4'hB;
      7'b1000110: w_nib = 4'hC;
      7'b0100001: w_nib = 4'hD;
      7'b0000110: w_nib = 4'hE;
      7'b0001110: w_nib = 4'hF;
      7'b1111111: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default:    w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_in_range = ({1'b0, Sel_in} < 4'(NUM_DIGITS));
    w_match    = (Sel_in == r_last_sel) && (Seg_in == r_last_seg);
    if (!w_match)
      w_cnt_next = CW'(1);
    else if (r_cnt == SAT)
      w_cnt_next = SAT;
    else
      w_cnt_next = r_cnt + CW'(1);
    // A mismatching sample starts a fresh run, which alone completes it when SAT == 1
    w_commit = Sel_valid && w_in_range && (w_cnt_next == SAT) &&
               (!w_match || (r_cnt != SAT));
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      w_seen_next[i] = r_seen[i] | (w_commit && (Sel_in == 3'(i)));
    w_frame = w_commit && (&w_seen_next);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last_sel   <= '0;
      r_last_seg   <= '1;
      r_cnt        <= '0;
      r_seen       <= '0;
      r_hex        <= '0;
      r_valid      <= '0;
      r_err        <= '0;
      r_update     <= 1'b0;
      r_update_idx <= '0;
      r_frame      <= 1'b0;
    end else begin
      r_update <= w_commit;
      r_frame  <= w_frame;
      r_seen   <= w_frame ? '0 : w_seen_next;
      if (Sel_valid) begin
        if (w_in_range) begin
          r_last_sel <= Sel_in;
          r_last_seg <= Seg_in;
          r_cnt      <= w_cnt_next;
        end else begin
          r_cnt <= '0;
        end
      end
      if (w_commit)
        r_update_idx <= Sel_in;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (w_commit && (Sel_in == 3'(i))) begin
          if (w_legal) begin
            r_hex[4*i +: 4] <= w_nib;
            r_valid[i]      <= 1'b1;
            r_err[i]        <= 1'b0;
          end else if (w_blank) begin
            r_hex[4*i +: 4] <= '0;
            r_valid[i]      <= 1'b0;
            r_err[i]        <= 1'b0;
          end else begin
            r_valid[i]      <= 1'b0;
            r_err[i]        <= 1'b1;
          end
        end
      end
    end
  end

  assign Hex_out     = r_hex;
  assign Digit_valid = r_valid;
  assign Digit_err   = r_err;
  assign Update      = r_update;
  assign Update_idx  = r_update_idx;
  assign Frame_done  = r_frame;

endmodule

// File: tb/tb_hex_scan_decoder.sv
// Directed bench for hex_scan_decoder: hand-computed expectations for commit,
// glyph decode, frame tracking, out-of-range indices and mid-run reset.
module tb_hex_scan_decoder;

  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_BLK = 7'b1111111;
  localparam logic [6:0] SEG_BAD = 7'b1011011;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Sel_valid;
  logic [2:0]  Sel_in;
  logic [6:0]  Seg_in;
  logic [23:0] Hex_out;
  logic [5:0]  Digit_valid;
  logic [5:0]  Digit_err;
  logic        Update;
  logic [2:0]  Update_idx;
  logic        Frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int upd   = 0;
  int frm   = 0;

  logic [6:0] frame_seg [6];

  hex_scan_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Sel_valid   (Sel_valid),
    .Sel_in      (Sel_in),
    .Seg_in      (Seg_in),
    .Hex_out     (Hex_out),
    .Digit_valid (Digit_valid),
    .Digit_err   (Digit_err),
    .Update      (Update),
    .Update_idx  (Update_idx),
    .Frame_done  (Frame_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, observe 1 time unit after the rising edge
  task automatic sample(input logic v, input logic [2:0] sel, input logic [6:0] seg);
    @(negedge Clk);
    Sel_valid = v;
    Sel_in    = sel;
    Seg_in    = seg;
    @(posedge Clk);
    #1;
    upd += int'(Update);
    frm += int'(Frame_done);
  endtask

  task automatic run(input logic [2:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) sample(1'b1, sel, seg);
  endtask

  initial begin
    frame_seg[0] = SEG_1; frame_seg[1] = SEG_2; frame_seg[2] = SEG_3;
    frame_seg[3] = SEG_4; frame_seg[4] = SEG_5; frame_seg[5] = SEG_6;
    Reset_n   = 1'b0;
    Sel_valid = 1'b0;
    Sel_in    = '0;
    Seg_in    = '1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check("rst_hex",   32'(Hex_out),     32'h0);
    check("rst_valid", 32'(Digit_valid), 32'h0);
    check("rst_err",   32'(Digit_err),   32'h0);
    check("rst_upd",   32'(Update),      32'h0);
    check("rst_idx",   32'(Update_idx),  32'h0);
    check("rst_frame", 32'(Frame_done),  32'h0);

    // Basic commit of digit 2 after four stable samples, no recommit when held
    upd = 0;
    run(3'd2, SEG_2, 3);
    check("d2_early_upd", 32'(upd), 32'd0);
    sample(1'b1, 3'd2, SEG_2);
    check("d2_upd",   32'(Update),        32'd1);
    check("d2_idx",   32'(Update_idx),    32'd2);
    check("d2_nib",   32'(Hex_out[11:8]), 32'h2);
    check("d2_valid", 32'(Digit_valid),   32'b000100);
    upd = 0;
    run(3'd2, SEG_2, 5);
    check("d2_hold_upd", 32'(upd), 32'd0);

    // Digit switch restarts the run; idle gaps do not break it
    upd = 0;
    run(3'd0, SEG_1, 3);
    run(3'd1, SEG_2, 1);
    sample(1'b1, 3'd0, SEG_1);
    sample(1'b0, 3'd5, SEG_BAD);
    sample(1'b1, 3'd0, SEG_1);
    sample(1'b0, 3'd5, SEG_BAD);
    sample(1'b1, 3'd0, SEG_1);
    check("sw_no_upd", 32'(upd), 32'd0);
    sample(1'b1, 3'd0, SEG_1);
    check("sw_upd",   32'(Update),       32'd1);
    check("sw_idx",   32'(Update_idx),   32'd0);
    check("sw_nib0",  32'(Hex_out[3:0]), 32'h1);
    check("sw_nib1",  32'(Hex_out[7:4]), 32'h0);
    check("sw_valid", 32'(Digit_valid),  32'b000101);

    // Legal -> illegal -> blank on digit 3
    run(3'd3, SEG_A, 4);
    check("d3_nibA",   32'(Hex_out[15:12]), 32'hA);
    check("d3_validA", 32'(Digit_valid),    32'b001101);
    run(3'd3, SEG_BAD, 4);
    check("bad_upd",   32'(Update),          32'd1);
    check("bad_err",   32'(Digit_err),       32'b001000);
    check("bad_valid", 32'(Digit_valid),     32'b000101);
    check("bad_nib",   32'(Hex_out[15:12]),  32'hA);
    run(3'd3, SEG_BLK, 4);
    check("blk_err",   32'(Digit_err),       32'h0);
    check("blk_valid", 32'(Digit_valid),     32'b000101);
    check("blk_nib",   32'(Hex_out[15:12]),  32'h0);

    // Full frame 0..5 = 1..6, twice
    frm = 0;
    for (int d = 0; d < 5; d++) run(3'(d), frame_seg[d], 4);
    check("f1_early", 32'(frm), 32'd0);
    run(3'd5, SEG_6, 4);
    check("f1_pulse", 32'(Frame_done),  32'd1);
    check("f1_hex",   32'(Hex_out),     32'h654321);
    check("f1_valid", 32'(Digit_valid), 32'h3F);
    check("f1_err",   32'(Digit_err),   32'h0);
    sample(1'b0, 3'd0, SEG_BLK);
    check("f1_drop",  32'(Frame_done),  32'd0);
    check("f1_udrop", 32'(Update),      32'd0);
    frm = 0;
    for (int d = 0; d < 6; d++) run(3'(d), frame_seg[d], 4);
    check("f2_pulse", 32'(Frame_done), 32'd1);
    check("f2_count", 32'(frm),        32'd1);

    // Out-of-range index inside a digit-1 run restarts the run
    upd = 0;
    frm = 0;
    run(3'd1, SEG_7, 2);
    sample(1'b1, 3'd7, SEG_7);
    check("oor_upd", 32'(Update),     32'd0);
    check("oor_idx", 32'(Update_idx), 32'd5);
    run(3'd1, SEG_7, 3);
    check("oor_no_upd", 32'(upd),          32'd0);
    check("oor_nib_old", 32'(Hex_out[7:4]), 32'h2);
    sample(1'b1, 3'd1, SEG_7);
    check("oor_commit", 32'(Update),       32'd1);
    check("oor_cidx",   32'(Update_idx),   32'd1);
    check("oor_nib",    32'(Hex_out[7:4]), 32'h7);
    check("oor_frame",  32'(frm),          32'd0);

    // Reset mid-run discards the partial run
    run(3'd4, SEG_4, 3);
    @(negedge Clk);
    Sel_valid = 1'b0;
    Reset_n   = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    sample(1'b1, 3'd4, SEG_4);
    check("mr_upd",   32'(Update),      32'd0);
    check("mr_hex",   32'(Hex_out),     32'h0);
    check("mr_valid", 32'(Digit_valid), 32'h0);
    check("mr_err",   32'(Digit_err),   32'h0);
    check("mr_idx",   32'(Update_idx),  32'h0);
    check("mr_frame", 32'(Frame_done),  32'h0);
    run(3'd4, SEG_4, 3);
    check("mr_commit", 32'(Update),  32'd1);
    check("mr_hex4",   32'(Hex_out), 32'h040000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
